// File: rtl/gp_pkg.sv
// Types shared by the graphics-processor pixel path.
// Pixel and RAM-address widths match the 256x12 RAM macro.
package gp_pkg;

   localparam int GP_AW = 8;
   localparam int GP_DW = 12;

   typedef logic [GP_DW-1:0] pixel_t;
   typedef logic [GP_AW-1:0] ram_addr_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } rdr_state_t;

endpackage

// File: rtl/ram256x12_stream_reader_pixel_fifo.sv
// Synchronous FIFO of {last, pixel} entries with registered head outputs.
// The head register is loaded from the entry that becomes oldest after this cycle's push/pop.
module pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     push_last,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     out_valid,
   output logic [DW-1:0]            out_data,
   output logic                     out_last
);

   localparam int PW = $clog2(DEPTH);

   logic [DW:0]   mem_reg [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] rd_ptr_next;
   logic [PW:0]   count_reg;
   logic [PW:0]   count_next;
   logic [DW:0]   head_next;
   logic          do_pop;

   assign do_pop = pop && (count_reg != '0);
   assign count  = count_reg;

   always_comb begin
      rd_ptr_next = rd_ptr_reg + PW'(do_pop);
      count_next  = count_reg + (PW+1)'(push) - (PW+1)'(do_pop);
      head_next   = mem_reg[rd_ptr_next];
      // A push landing on the new head slot bypasses storage (empty, or single entry popped).
      if (push && (wr_ptr_reg == rd_ptr_next))
         head_next = {push_last, push_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_reg[i] <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
      end else begin
         if (push) begin
            mem_reg[wr_ptr_reg] <= {push_last, push_data};
            wr_ptr_reg          <= wr_ptr_reg + PW'(1);
         end
         rd_ptr_reg            <= rd_ptr_next;
         count_reg             <= count_next;
         out_valid             <= (count_next != '0);
         {out_last, out_data}  <= head_next;
      end
   end

   no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !do_pop && (count_reg == (PW+1)'(DEPTH))));

endmodule

// File: rtl/ram256x12_stream_reader.sv
// Fetches a run of consecutive RAM pixels on a start command and streams them out
// valid/ready with a last marker; the FIFO soaks up the RAM's one-cycle read latency.
module ram256x12_stream_reader
   import gp_pkg::*;
#(
   parameter int AW         = 8,
   parameter int DW         = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic [AW-1:0] i_base,
   input  logic [AW:0]   i_len,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_re,
   output logic [AW-1:0] o_raddr,
   input  logic [DW-1:0] i_rdata,
   output logic          o_valid,
   output logic [DW-1:0] o_pixel,
   output logic          o_last,
   input  logic          i_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rdr_state_t    state_reg;
   rdr_state_t    state_next;
   logic [AW-1:0] addr_reg;
   logic [AW-1:0] last_addr_reg;
   logic [AW:0]   issue_cnt_reg;
   logic [AW:0]   deliver_cnt_reg;
   logic          inflight_reg;
   logic          done_reg;
   logic [CW-1:0] fifo_count;
   logic          issue;
   logic          pop;
   logic          finish;
   logic          start_run;
   logic          start_empty;

   assign pop     = o_valid && i_ready;
   assign o_busy  = (state_reg != IDLE);
   assign o_done  = done_reg;
   assign o_re    = issue;
   assign o_raddr = issue ? addr_reg : last_addr_reg;

   always_comb begin
      state_next  = state_reg;
      issue       = 1'b0;
      finish      = 1'b0;
      start_run   = 1'b0;
      start_empty = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_start) begin
               if (i_len != '0) begin
                  start_run  = 1'b1;
                  state_next = FETCH;
               end else begin
                  start_empty = 1'b1;
               end
            end
         end
         FETCH: begin
            // Reads already in the RAM pipe count against FIFO space.
            if (({1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg}) < (CW+1)'(FIFO_DEPTH)) begin
               issue = 1'b1;
               if (issue_cnt_reg == (AW+1)'(1))
                  state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && (deliver_cnt_reg == (AW+1)'(1))) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg       <= IDLE;
         addr_reg        <= '0;
         last_addr_reg   <= '0;
         issue_cnt_reg   <= '0;
         deliver_cnt_reg <= '0;
         inflight_reg    <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= issue;
         done_reg     <= finish || start_empty;
         if (start_run) begin
            addr_reg        <= i_base;
            issue_cnt_reg   <= i_len;
            deliver_cnt_reg <= i_len;
         end else begin
            if (issue) begin
               addr_reg      <= addr_reg + AW'(1);
               last_addr_reg <= addr_reg;
               issue_cnt_reg <= issue_cnt_reg - (AW+1)'(1);
            end
            if (pop)
               deliver_cnt_reg <= deliver_cnt_reg - (AW+1)'(1);
         end
      end
   end

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .push      (inflight_reg),
      .push_data (i_rdata),
      .push_last (issue_cnt_reg == '0),
      .pop       (pop),
      .count     (fifo_count),
      .out_valid (o_valid),
      .out_data  (o_pixel),
      .out_last  (o_last)
   );

endmodule

// File: doc/ram256x12_stream_reader.md
# ram256x12_stream_reader

Read-side companion of the 256×12 pixel RAM macro. On a start command it fetches a run of pixels from consecutive RAM addresses, absorbs the RAM's one-cycle registered read latency in a small FIFO, and presents the pixels as a valid/ready stream with a last marker. It sits between the line/palette RAM and downstream pixel consumers in the graphics processor, such as the scanout serializer and the blitter.

## Interface
Parameters:
- AW, 8: RAM address width; addresses wrap modulo 2^AW.
- DW, 12: pixel width (RGB444).
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥ 3.

Ports:
- i_clk  in  1  single clock for the block and the attached RAM.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle command pulse; ignored while o_busy=1.
- i_base  in  AW  first address, sampled with i_start.
- i_len  in  AW+1  pixel count, 0..256, sampled with i_start.
- o_busy  out  1  command in progress.
- o_done  out  1  one-cycle completion pulse.
- o_re  out  1  RAM read enable.
- o_raddr  out  AW  RAM read address.
- i_rdata  in  DW  RAM read data, valid the cycle after o_re.
- o_valid  out  1  stream data valid.
- o_pixel  out  DW  stream pixel.
- o_last  out  1  marks the final pixel of the command; qualified by o_valid.
- i_ready  in  1  downstream accepts when high together with o_valid.

## Operation
- Reset values: o_busy=0, o_done=0, o_re=0, o_raddr=0, o_valid=0, o_pixel=0, o_last=0, FSM=IDLE, all counters and the FIFO cleared.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - i_start with i_len≠0: latch the address counter to i_base and the issue and deliver counters to i_len, set o_busy, go to FETCH.
  - i_start with i_len=0: pulse o_done in the next cycle; no reads, o_busy stays 0.
- FETCH:
  - A read issues when (fifo_count + inflight) < FIFO_DEPTH. Both terms are registered values.
  - On issue: o_re=1, o_raddr=address counter. Increment the address with wrap (0xFF→0x00) and decrement the issue counter.
  - When the last read issues, go to DRAIN.
- inflight:
  - 1-bit register, set in the cycle after an issue.
  - In that cycle i_rdata is pushed into the FIFO, tagged last when the issue counter has reached 0.
- DRAIN: stays until the FIFO is empty and the last-tagged pixel has been accepted, then goes to IDLE. o_busy clears and o_done pulses for one cycle.
- Stream handshake:
  - Transfer occurs when o_valid && i_ready.
  - o_valid, o_pixel and o_last hold stable while o_valid=1 and i_ready=0.
  - o_valid never depends combinationally on i_ready.
- FIFO:
  - Push and pop in the same cycle are allowed, including when full or when the FIFO holds one entry.
  - Overflow cannot occur by construction; an overflow is an assertion failure.
- o_re stays low outside FETCH. o_raddr holds its last value when o_re=0.
- Reset mid-command: everything returns to reset values immediately. No o_done is produced, and any RAM data arriving afterwards is ignored.

## Timing
- i_start sampled at edge 0:
  - first o_re in cycle 1;
  - i_rdata in cycle 2;
  - first o_valid in cycle 3.
- Throughput with i_ready held high is 1 pixel per cycle. A len-N command completes its last transfer in cycle N+2 and asserts o_done in cycle N+3.
- o_done and o_busy deassertion occur in the same cycle, one cycle after the last handshake. A new i_start is accepted in that cycle.
- Backpressure: once i_ready drops, at most FIFO_DEPTH pixels are fetched ahead of consumption.

## Structure
- Shared package gp_pkg holds:
  - pixel_t (logic [DW-1:0]);
  - ram_addr_t (logic [AW-1:0]);
  - the rdr_state_t enum {IDLE, FETCH, DRAIN}.
- Sub-module pixel_fifo: synchronous FIFO of {last, pixel} entries, parameterized on depth, with count output and registered outputs. It is reusable by other stream blocks.
- The top level contains the FSM, the address, issue and deliver counters, and the inflight flag.

## Test plan
- Basic: RAM[0x10..0x13]=0x111,0x222,0x333,0x444; base=0x10, len=4, ready=1 → pixels in that order in cycles 3–6, o_last only on 0x444, o_done in cycle 7.
- Wrap: base=0xFE, len=4 → o_raddr sequence 0xFE,0xFF,0x00,0x01; pixels match RAM contents.
- Backpressure: len=16 with ready toggling on a 1-of-3 pattern → all 16 pixels delivered in order, no drops or duplicates, data stable while stalled, inflight+count never exceeds 4.
- Edge lengths:
  - len=0 → o_done one cycle later with no o_re;
  - len=256 → 256 pixels with o_last on the 256th;
  - i_start while busy → ignored.
- Reset: assert i_rst_n=0 in the middle of a len=8 command → all outputs 0 at once, no o_done; a subsequent command runs correctly.
